// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker FSM states and standard LFSR polynomials.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_VERIFY  = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } prbs_state_e;

  // PRBS7: x^7 + x^6 + 1
  localparam int PRBS7_LEN   = 7;
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;

  // PRBS15: x^15 + x^14 + 1
  localparam int PRBS15_LEN   = 15;
  localparam int PRBS15_TAP_A = 14;
  localparam int PRBS15_TAP_B = 13;

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR shared by the PRBS checker and generator; either loads an external bit
// or self-runs from its own feedback.
module prbs_lfsr #(
  parameter int LEN   = 7,
  parameter int TAP_A = 6,
  parameter int TAP_B = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  input  logic           load_i,
  input  logic           bit_i,
  output logic           fb_o,
  output logic [LEN-1:0] next_o
);

  logic [LEN-1:0] s_q, s_d;

  assign fb_o   = s_q[TAP_A] ^ s_q[TAP_B];
  // State that would result from shifting in bit_i; lets the owner reject an all-zero seed.
  assign next_o = {s_q[LEN-2:0], bit_i};

  always_comb begin
    s_d = s_q;
    if (en_i) begin
      s_d = load_i ? next_o : {s_q[LEN-2:0], fb_o};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: seeds from the stream, verifies, locks, then flags and counts errors.
// Define PRBS_CHECKER_BITCNT_EN to enable bit_count; otherwise bit_count is tied to zero.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LEN      = PRBS7_LEN,
  parameter int TAP_A    = PRBS7_TAP_A,
  parameter int TAP_B    = PRBS7_TAP_B,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_count,
  output logic             lock,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int SEED_W  = $clog2(LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_THR + 1);
  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(LEN - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THR - 1);

  prbs_state_e        state_q, state_d;
  logic [SEED_W-1:0]  seedCnt_q, seedCnt_d;
  logic [MATCH_W-1:0] matchCnt_q, matchCnt_d;
  logic [MISS_W-1:0]  missCnt_q, missCnt_d;
  logic [CNT_W-1:0]   errCount_q, errCount_d;
  logic               err_q, err_d;

  logic               lfsrEn, lfsrLoad, lfsrFb, bitMiss;
  logic [LEN-1:0]     lfsrNext;

  prbs_lfsr #(.LEN(LEN), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (lfsrEn),
    .load_i (lfsrLoad),
    .bit_i  (in_bit),
    .fb_o   (lfsrFb),
    .next_o (lfsrNext)
  );

  assign bitMiss = in_bit ^ lfsrFb;

  always_comb begin
    state_d    = state_q;
    seedCnt_d  = seedCnt_q;
    matchCnt_d = matchCnt_q;
    missCnt_d  = missCnt_q;
    lfsrEn     = 1'b0;
    lfsrLoad   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_SEARCH: if (in_valid) begin
        lfsrEn   = 1'b1;
        lfsrLoad = 1'b1;
        if (seedCnt_q == SEED_LAST) begin
          seedCnt_d  = '0;
          matchCnt_d = '0;
          // An all-zero seed is the LFSR lock-up state, so keep searching.
          if (lfsrNext != '0) state_d = ST_VERIFY;
        end else begin
          seedCnt_d = seedCnt_q + 1'b1;
        end
      end
      ST_VERIFY: if (in_valid) begin
        lfsrEn = 1'b1;
        if (bitMiss) begin
          state_d    = ST_SEARCH;
          seedCnt_d  = '0;
          matchCnt_d = '0;
        end else if (matchCnt_q == MATCH_LAST) begin
          state_d    = ST_LOCKED;
          matchCnt_d = '0;
          missCnt_d  = '0;
        end else begin
          matchCnt_d = matchCnt_q + 1'b1;
        end
      end
      ST_LOCKED: if (in_valid) begin
        lfsrEn = 1'b1;
        if (bitMiss) begin
          err_d = 1'b1;
          if (missCnt_q == MISS_LAST) begin
            state_d   = ST_SEARCH;
            seedCnt_d = '0;
            missCnt_d = '0;
          end else begin
            missCnt_d = missCnt_q + 1'b1;
          end
        end else begin
          missCnt_d = '0;
        end
      end
      ST_ILLEGAL: begin
        state_d    = ST_SEARCH;
        seedCnt_d  = '0;
        matchCnt_d = '0;
        missCnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    errCount_d = errCount_q;
    if (clr_count) begin
      errCount_d = '0;
    end else if (err_d && (errCount_q != '1)) begin
      errCount_d = errCount_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SEARCH;
      seedCnt_q  <= '0;
      matchCnt_q <= '0;
      missCnt_q  <= '0;
      errCount_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seedCnt_q  <= seedCnt_d;
      matchCnt_q <= matchCnt_d;
      missCnt_q  <= missCnt_d;
      errCount_q <= errCount_d;
      err_q      <= err_d;
    end
  end

  assign lock      = (state_q == ST_LOCKED);
  assign err       = err_q;
  assign err_count = errCount_q;

`ifdef PRBS_CHECKER_BITCNT_EN
  logic [CNT_W-1:0] bitCount_q, bitCount_d;

  always_comb begin
    bitCount_d = bitCount_q;
    if (clr_count) begin
      bitCount_d = '0;
    end else if (in_valid && (state_q == ST_LOCKED) && (bitCount_q != '1)) begin
      bitCount_d = bitCount_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitCount_q <= '0;
    end else begin
      bitCount_q <= bitCount_d;
    end
  end

  assign bit_count = bitCount_q;
`else
  assign bit_count = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: scenario tasks push expected outputs to a scoreboard
// queue per sample and compare once the registered outputs settle.
module tb_prbs_checker;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_bit, clr_count;
  logic             lock, err;
  logic [CNT_W-1:0] err_count, bit_count;

  prbs_checker #(
    .LEN(7), .TAP_A(6), .TAP_B(5), .LOCK_CNT(8), .LOSS_THR(4), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_count (clr_count),
    .lock      (lock),
    .err       (err),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             lock;
    logic             err;
    logic [CNT_W-1:0] errCnt;
    logic [CNT_W-1:0] bitCnt;
  } exp_t;

  exp_t       sbQueue[$];
  exp_t       got;
  int         compared = 0;
  int         mismatched = 0;
  logic [6:0] genState;
  logic       modelLocked;
  int         expErrCnt, expBits;

  // Reference PRBS7 source, independent of the DUT.
  function automatic logic genNext();
    logic b;
    b = genState[6] ^ genState[5];
    genState = {genState[5:0], b};
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] bitsExp();
`ifdef PRBS_CHECKER_BITCNT_EN
    return CNT_W'(expBits);
`else
    return '0;
`endif
  endfunction

  task automatic resetModel();
    modelLocked = 1'b0;
    expErrCnt   = 0;
    expBits     = 0;
  endtask

  task automatic step(input logic v, input logic b, input logic c,
                      input logic nextLock, input logic expErr);
    if (v && modelLocked) expBits++;
    if (expErr) expErrCnt++;
    if (c) begin
      expBits   = 0;
      expErrCnt = 0;
    end
    modelLocked = nextLock;
    sbQueue.push_back({nextLock, expErr, CNT_W'(expErrCnt), bitsExp()});
    in_valid  = v;
    in_bit    = b;
    clr_count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    resetModel();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_bit = 1'b0; clr_count = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    resetModel();
    sbQueue.push_back('0);
    got = sbQueue.pop_front();
    compared++;
    if ({lock, err, err_count, bit_count} !== got) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want all zero",
               lock, err, err_count, bit_count);
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_clean_lock();
    logic b;
    genState = 7'h7F;
    for (int k = 1; k <= 35; k++) begin
      b = genNext();
      step(1'b1, b, 1'b0, k >= 15, 1'b0);
      got = sbQueue.pop_front();
      compared++;
      if ({lock, err, err_count, bit_count} !== got) begin
        mismatched++;
        $display("[TB] FAIL clean_lock #%0d: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want lock=%b err=%b errCnt=%0d bitCnt=%0d",
                 k, lock, err, err_count, bit_count, got.lock, got.err, got.errCnt, got.bitCnt);
      end
    end
  endtask

  task automatic test_single_error();
    logic b, inv;
    for (int k = 1; k <= 60; k++) begin
      b   = genNext();
      inv = (k == 50);
      step(1'b1, b ^ inv, 1'b0, 1'b1, inv);
      got = sbQueue.pop_front();
      compared++;
      if ({lock, err, err_count, bit_count} !== got) begin
        mismatched++;
        $display("[TB] FAIL single_error #%0d: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want lock=%b err=%b errCnt=%0d bitCnt=%0d",
                 k, lock, err, err_count, bit_count, got.lock, got.err, got.errCnt, got.bitCnt);
      end
    end
  endtask

  task automatic test_burst_loss();
    logic b, burst;
    for (int k = 1; k <= 24; k++) begin
      b     = genNext();
      burst = (k <= 4);
      // Lock drops with the 4th error, then 15 clean bits reseed and re-verify.
      step(1'b1, b ^ burst, 1'b0, burst ? (k < 4) : (k >= 19), burst);
      got = sbQueue.pop_front();
      compared++;
      if ({lock, err, err_count, bit_count} !== got) begin
        mismatched++;
        $display("[TB] FAIL burst_loss #%0d: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want lock=%b err=%b errCnt=%0d bitCnt=%0d",
                 k, lock, err, err_count, bit_count, got.lock, got.err, got.errCnt, got.bitCnt);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic b;
    b = genNext();
    step(1'b1, ~b, 1'b0, 1'b1, 1'b1);
    got = sbQueue.pop_front();
    compared++;
    if ({lock, err, err_count, bit_count} !== got) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_error: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want lock=%b err=%b errCnt=%0d bitCnt=%0d",
               lock, err, err_count, bit_count, got.lock, got.err, got.errCnt, got.bitCnt);
    end
    #2 reset = 1'b0;
    #1;
    resetModel();
    sbQueue.push_back('0);
    got = sbQueue.pop_front();
    compared++;
    if ({lock, err, err_count, bit_count} !== got) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_async: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want all zero",
               lock, err, err_count, bit_count);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      b = genNext();
      step(1'b1, b, 1'b0, k >= 15, 1'b0);
      got = sbQueue.pop_front();
      compared++;
      if ({lock, err, err_count, bit_count} !== got) begin
        mismatched++;
        $display("[TB] FAIL relock_after_reset #%0d: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want lock=%b err=%b errCnt=%0d bitCnt=%0d",
                 k, lock, err, err_count, bit_count, got.lock, got.err, got.errCnt, got.bitCnt);
      end
    end
  endtask

  task automatic test_zero_stream();
    pulseReset();
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      got = sbQueue.pop_front();
      compared++;
      if ({lock, err, err_count, bit_count} !== got) begin
        mismatched++;
        $display("[TB] FAIL zero_stream #%0d: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want lock=%b err=%b errCnt=%0d bitCnt=%0d",
                 k, lock, err, err_count, bit_count, got.lock, got.err, got.errCnt, got.bitCnt);
      end
    end
  endtask

  task automatic test_valid_toggle();
    logic       b;
    int         n;
    logic [3:0] tbl [4];
    logic [3:0] row;
    pulseReset();
    genState = 7'h7F;
    n = 0;
    for (int c = 0; c < 60 && n < 25; c++) begin
      if (c % 2 == 1) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, modelLocked, 1'b0);
      end else begin
        n++;
        b = genNext();
        step(1'b1, b, 1'b0, n >= 15, 1'b0);
      end
      got = sbQueue.pop_front();
      compared++;
      if ({lock, err, err_count, bit_count} !== got) begin
        mismatched++;
        $display("[TB] FAIL valid_toggle cyc %0d: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want lock=%b err=%b errCnt=%0d bitCnt=%0d",
                 c, lock, err, err_count, bit_count, got.lock, got.err, got.errCnt, got.bitCnt);
      end
    end
    // Rows are {valid, invert, clr_count, expected err}.
    tbl = '{4'b1101, 4'b0000, 4'b1111, 4'b1000};
    for (int r = 0; r < 4; r++) begin
      row = tbl[r];
      b = row[3] ? genNext() : 1'b0;
      step(row[3], b ^ row[2], row[1], 1'b1, row[0]);
      got = sbQueue.pop_front();
      compared++;
      if ({lock, err, err_count, bit_count} !== got) begin
        mismatched++;
        $display("[TB] FAIL clear_vs_error row %0d: got lock=%b err=%b errCnt=%0d bitCnt=%0d, want lock=%b err=%b errCnt=%0d bitCnt=%0d",
                 r, lock, err, err_count, bit_count, got.lock, got.err, got.errCnt, got.bitCnt);
      end
    end
  endtask

  initial begin
    resetModel();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_burst_loss();
    test_mid_reset();
    test_zero_stream();
    test_valid_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
